// File: rtl/instr_decode_stage.sv
// instr_decode_stage: RV32I/RV64I integer decode stage between fetch and execute.
// Decodes OP_IMM, OP, LUI and AUIPC into kind/func/registers/immediate and queues
// the result in a small in-order output FIFO.
// Optional feature macro: STRICT_DECODE_EN (full funct7 / shift-immediate checking).
module instr_decode_stage #(
  parameter int XLEN      = 32,
  parameter int BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2:0]      out_kind,
  output logic [3:0]      out_func,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_pc
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = $clog2(BUF_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [2:0] K_OP_IMM = 3'd1;
  localparam logic [2:0] K_OP     = 3'd2;
  localparam logic [2:0] K_LUI    = 3'd3;
  localparam logic [2:0] K_AUIPC  = 3'd4;

  localparam logic [3:0] F_ADD  = 4'd0;
  localparam logic [3:0] F_SUB  = 4'd1;
  localparam logic [3:0] F_SLT  = 4'd2;
  localparam logic [3:0] F_SLTU = 4'd3;
  localparam logic [3:0] F_AND  = 4'd4;
  localparam logic [3:0] F_OR   = 4'd5;
  localparam logic [3:0] F_XOR  = 4'd6;
  localparam logic [3:0] F_SLL  = 4'd7;
  localparam logic [3:0] F_SRL  = 4'd8;
  localparam logic [3:0] F_SRA  = 4'd9;

  typedef struct packed {
    logic [2:0]      kind;
    logic [3:0]      func;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
  } entry_t;

  entry_t          r_mem [BUF_DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic            r_alive;

  entry_t          w_dec;
  entry_t          w_head;
  logic            w_push;
  logic            w_pop;
  logic            w_bad;
  logic [2:0]      w_f3;
  logic            w_alt;
  logic            w_is_shift;
  logic [3:0]      w_func_base;
  logic [5:0]      w_shamt;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_u;

  assign w_f3       = in_instr[14:12];
  assign w_alt      = in_instr[30];
  assign w_is_shift = (w_f3 == 3'b001) || (w_f3 == 3'b101);
  assign w_imm_i    = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
  assign w_imm_u    = {{(XLEN-31){in_instr[31]}}, in_instr[30:12], 12'b0};

`ifdef STRICT_DECODE_EN
  logic [6:0] w_f7;
  logic       w_shift_hi_nz;
  assign w_f7 = in_instr[31:25];
`endif

  // Shift amount width follows XLEN; bit 25 belongs to shamt only on RV64
  generate
    if (XLEN == 64) begin : g_shamt64
      assign w_shamt = in_instr[25:20];
`ifdef STRICT_DECODE_EN
      assign w_shift_hi_nz = |{in_instr[31], in_instr[29:26]};
`endif
    end else begin : g_shamt32
      assign w_shamt = {1'b0, in_instr[24:20]};
`ifdef STRICT_DECODE_EN
      assign w_shift_hi_nz = |{in_instr[31], in_instr[29:25]};
`endif
    end
  endgenerate

  // Base ALU function selected by funct3 (alternate forms patched in decode)
  always_comb begin
    case (w_f3)
      3'b000:  w_func_base = F_ADD;
      3'b001:  w_func_base = F_SLL;
      3'b010:  w_func_base = F_SLT;
      3'b011:  w_func_base = F_SLTU;
      3'b100:  w_func_base = F_XOR;
      3'b101:  w_func_base = F_SRL;
      3'b110:  w_func_base = F_OR;
      default: w_func_base = F_AND;
    endcase
  end

  // Decode the incoming word into a FIFO entry; illegal forms become UNKNOWN
  always_comb begin
    w_dec    = '0;
    w_bad    = 1'b0;
    w_dec.pc = in_pc;
    case (in_instr[6:0])
      OPC_OP_IMM: begin
        w_dec.kind = K_OP_IMM;
        w_dec.rd   = in_instr[11:7];
        w_dec.rs1  = in_instr[19:15];
        w_dec.func = w_func_base;
        if (w_is_shift) begin
          w_dec.imm = XLEN'(w_shamt);
          if ((w_f3 == 3'b101) && w_alt) w_dec.func = F_SRA;
`ifdef STRICT_DECODE_EN
          w_bad = w_shift_hi_nz | (w_alt & (w_f3 != 3'b101));
`endif
        end else begin
          w_dec.imm = w_imm_i;
        end
      end
      OPC_OP: begin
        w_dec.kind = K_OP;
        w_dec.rd   = in_instr[11:7];
        w_dec.rs1  = in_instr[19:15];
        w_dec.rs2  = in_instr[24:20];
        w_dec.func = w_func_base;
        if (w_alt && (w_f3 == 3'b000)) w_dec.func = F_SUB;
        if (w_alt && (w_f3 == 3'b101)) w_dec.func = F_SRA;
`ifdef STRICT_DECODE_EN
        w_bad = !((w_f7 == 7'b0000000) ||
                  ((w_f7 == 7'b0100000) && ((w_f3 == 3'b000) || (w_f3 == 3'b101))));
`endif
      end
      OPC_LUI, OPC_AUIPC: begin
        w_dec.kind = (in_instr[6:0] == OPC_LUI) ? K_LUI : K_AUIPC;
        w_dec.rd   = in_instr[11:7];
        w_dec.func = F_ADD;
        w_dec.imm  = w_imm_u;
      end
      default: ;
    endcase
    if (w_bad) begin
      w_dec    = '0;
      w_dec.pc = in_pc;
    end
  end

  assign in_ready  = rst_n & r_alive & ~flush & (r_count < DEPTH_C);
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  // FIFO pointers, occupancy and the post-reset enable; flush empties everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_alive <= 1'b0;
    end else begin
      r_alive <= 1'b1;
      if (flush) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + 1'b1;
        if (w_pop)  r_rptr <= r_rptr + 1'b1;
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Entry storage; contents are only meaningful where the count says so
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_dec;
  end

  assign w_head   = out_valid ? r_mem[r_rptr] : '0;
  assign out_kind = w_head.kind;
  assign out_func = w_head.func;
  assign out_rd   = w_head.rd;
  assign out_rs1  = w_head.rs1;
  assign out_rs2  = w_head.rs2;
  assign out_imm  = w_head.imm;
  assign out_pc   = w_head.pc;

endmodule
